frame_capture_sequencer: RTL and testbench
==========================================

# frame_capture_sequencer

Sequences capture of framed byte streams arriving on the shared 8-bit data bus into the team's small capture buffer RAM. The block hunts for the AA/55 sync pair, then reads a length byte, writes that many payload bytes to consecutive buffer addresses, and verifies a trailing 8-bit checksum. It then holds the frame for a downstream consumer until acknowledged. It sits between the bus and the buffer and is the sole source of the buffer's write strobe, address and data.

## Interface
- SYNC1, 8'hAA, first sync byte
- SYNC2, 8'h55, second sync byte
- AW, 4, buffer address width (depth 2^AW)
- MAXLEN, 16, largest legal payload length (1..2^AW)
- TIMEOUT, 16, idle cycles without DVALID before a frame in progress is abandoned (≥2)

- CLK  in  1  clock, rising edge
- RST_N  in  1  reset; synchronous, active-low
- DBUS  in  8  incoming byte
- DVALID  in  1  DBUS holds a valid byte this cycle
- WREN  out  1  buffer write strobe
- WADDR  out  AW  buffer write address
- WDATA  out  8  buffer write data
- FRAME_RDY  out  1  a verified frame is held in the buffer
- FRAME_LEN  out  AW+1  payload length of the held frame
- FRAME_ACK  in  1  consumer releases the held frame
- ERR  out  1  one-cycle error pulse
- ERR_CODE  out  2  01 timeout, 10 bad length, 11 bad checksum; holds the last code

## Operation
- Bytes are accepted only in cycles where DVALID=1; all other DBUS values are ignored.
- HUNT: a byte equal to SYNC1 moves to SYNC.
- SYNC: SYNC2 moves to LEN; SYNC1 stays in SYNC (resync); any other byte returns to HUNT without raising ERR.
- LEN: byte L. L=0 or L>MAXLEN returns to HUNT with ERR, code 10. Otherwise L is latched, cnt=0, sum=0, and the FSM moves to PAYLOAD.
- PAYLOAD: each byte is written at WADDR=cnt with WDATA=byte; sum=(sum+byte) mod 256; cnt increments. The byte with cnt=L-1 moves to CHECK.
- CHECK: byte C. C==sum moves to HOLD. Otherwise the FSM returns to HUNT with ERR, code 11; buffer contents are undefined.
- HOLD: FRAME_RDY=1 and FRAME_LEN=L. All DBUS traffic is ignored, sync bytes included. FRAME_ACK=1 returns to HUNT.
- FRAME_ACK is ignored in every state except HOLD.
- Timeout: an idle counter clears on every accepted byte and counts cycles with DVALID=0 while in SYNC, LEN, PAYLOAD or CHECK. When it reaches TIMEOUT, the FSM returns to HUNT with ERR, code 01. The counter is inactive in HUNT and HOLD.
- Length wrap: cnt is AW+1 bits wide; WADDR=cnt[AW-1:0]. MAXLEN ≤ 2^AW guarantees no address wrap.

## Timing
- Reset (RST_N=0 at a rising edge): state HUNT, and WREN, WADDR, WDATA, FRAME_RDY, FRAME_LEN, ERR, ERR_CODE, cnt, sum and idle counter all 0.
- Reset mid-frame or in HOLD aborts immediately; no ERR is raised.
- All outputs are registered. WREN/WADDR/WDATA assert in the cycle after the payload byte is sampled, for exactly one cycle per byte.
- Back-to-back payload bytes produce WREN high on consecutive cycles.
- FRAME_RDY rises in the cycle after the matching checksum byte is sampled.
- FRAME_RDY falls in the cycle after FRAME_ACK is sampled high. A SYNC1 byte sampled in that same ACK cycle is ignored.
- ERR pulses in the cycle after the offending byte, or after the TIMEOUT-th idle cycle. ERR_CODE updates in the same cycle.
- The earliest next frame is the SYNC1 byte sampled one cycle after any return to HUNT.

## Structure
- Shared package: state encoding (HUNT, SYNC, LEN, PAYLOAD, CHECK, HOLD), ERR_CODE constants, and default SYNC1/SYNC2 values.
- Sub-module: idle_timeout_counter, with clear, enable, TIMEOUT parameter and an expired output.
- Top level holds the FSM, cnt/sum registers and output registers.

## Test plan
- Good frame: AA 55 03 11 22 33 66 with DVALID every cycle → WREN at addresses 0,1,2 with data 11,22,33; FRAME_RDY=1 with FRAME_LEN=3. An ACK 5 cycles later drops FRAME_RDY the next cycle.
- Bad checksum: AA 55 02 10 20 31 → two writes, then ERR pulse with ERR_CODE=11, state HUNT, FRAME_RDY stays 0.
- Bad length: AA 55 00, then AA 55 11 (MAXLEN=16) → ERR with code 10 each time, no WREN.
- Resync plus gaps: AA AA 55 01 7F 7F with DVALID low for 3 cycles between bytes → frame accepted, FRAME_LEN=1, write at address 0 with data 7F.
- Timeout and hold: AA 55 04 01, then DVALID low for 16 cycles → ERR code 01 and state HUNT. Separately, while in HOLD, a full second frame is ignored: no WREN, FRAME_LEN unchanged.
- Reset mid-payload: RST_N low for 1 cycle after the second payload byte → all outputs 0, no ERR, and the next good frame is captured from address 0.

Source files
------------

// File: rtl/frame_capture_sequencer_pkg.sv
// Shared constants for the frame capture sequencer: FSM state encoding,
// error codes and the default sync byte pair.
package frame_capture_sequencer_pkg;

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CHECK   = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BADLEN  = 2'b10;
  localparam logic [1:0] ERR_BADSUM  = 2'b11;

  localparam logic [7:0] SYNC1_DEFAULT = 8'hAA;
  localparam logic [7:0] SYNC2_DEFAULT = 8'h55;

  // States in which a stalled sender can leave a frame half-received.
  function automatic logic in_frame(input logic [2:0] st);
    return (st == ST_SYNC) || (st == ST_LEN) || (st == ST_PAYLOAD) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/frame_capture_sequencer_idle.sv
// Idle cycle counter: expired is raised combinationally during the
// TIMEOUT-th consecutive enabled cycle so the caller can act on that edge.
module idle_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  assign expired = enable && (count == LAST);

  always_ff @(posedge CLK) begin
    if (!RST_N || clear || expired) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/frame_capture_sequencer.sv
// Hunts for a sync pair on the byte bus, captures the length-prefixed payload
// into the buffer RAM, verifies the checksum and holds the frame until acked.
module frame_capture_sequencer
  import frame_capture_sequencer_pkg::*;
#(
  parameter logic [7:0] SYNC1   = SYNC1_DEFAULT,
  parameter logic [7:0] SYNC2   = SYNC2_DEFAULT,
  parameter int         AW      = 4,
  parameter int         MAXLEN  = 16,
  parameter int         TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [7:0]    DBUS,
  input  logic          DVALID,
  output logic          WREN,
  output logic [AW-1:0] WADDR,
  output logic [7:0]    WDATA,
  output logic          FRAME_RDY,
  output logic [AW:0]   FRAME_LEN,
  input  logic          FRAME_ACK,
  output logic          ERR,
  output logic [1:0]    ERR_CODE
);

  localparam logic [7:0] MAXLEN_B = 8'(MAXLEN);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [2:0]  state;
  logic [AW:0] cnt;
  logic [AW:0] len;
  logic [7:0]  sum;
  logic        idle_clear;
  logic        idle_enable;
  logic        timeout;

  assign idle_enable = in_frame(state) && !DVALID;
  assign idle_clear  = DVALID || !in_frame(state);

  idle_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_idle (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clear  (idle_clear),
    .enable (idle_enable),
    .expired(timeout)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_HUNT;
      WREN      <= 1'b0;
      WADDR     <= '0;
      WDATA     <= '0;
      FRAME_RDY <= 1'b0;
      FRAME_LEN <= '0;
      ERR       <= 1'b0;
      ERR_CODE  <= ERR_NONE;
      cnt       <= '0;
      len       <= '0;
      sum       <= '0;
    end else begin
      WREN <= 1'b0;
      ERR  <= 1'b0;
      if (timeout) begin
        state    <= ST_HUNT;
        ERR      <= 1'b1;
        ERR_CODE <= ERR_TIMEOUT;
      end else begin
        case (state)
          ST_HUNT: begin
            if (DVALID && DBUS == SYNC1) state <= ST_SYNC;
          end
          // A repeated SYNC1 keeps us aligned on the most recent candidate.
          ST_SYNC: begin
            if (DVALID) begin
              if (DBUS == SYNC2)      state <= ST_LEN;
              else if (DBUS != SYNC1) state <= ST_HUNT;
            end
          end
          ST_LEN: begin
            if (DVALID) begin
              if (DBUS == 8'h00 || DBUS > MAXLEN_B) begin
                state    <= ST_HUNT;
                ERR      <= 1'b1;
                ERR_CODE <= ERR_BADLEN;
              end else begin
                len   <= DBUS[AW:0];
                cnt   <= '0;
                sum   <= 8'h00;
                state <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (DVALID) begin
              WREN  <= 1'b1;
              WADDR <= cnt[AW-1:0];
              WDATA <= DBUS;
              sum   <= sum + DBUS;
              cnt   <= cnt + CNT_ONE;
              if (cnt + CNT_ONE == len) state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (DVALID) begin
              if (DBUS == sum) begin
                state     <= ST_HOLD;
                FRAME_RDY <= 1'b1;
                FRAME_LEN <= len;
              end else begin
                state    <= ST_HUNT;
                ERR      <= 1'b1;
                ERR_CODE <= ERR_BADSUM;
              end
            end
          end
          ST_HOLD: begin
            if (FRAME_ACK) begin
              state     <= ST_HUNT;
              FRAME_RDY <= 1'b0;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_sequencer.sv
// Directed, table-driven bench for frame_capture_sequencer: each vector gives
// one cycle of inputs and the outputs expected just after that rising edge.
module tb_frame_capture_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] DBUS;
  logic       DVALID;
  logic       WREN;
  logic [3:0] WADDR;
  logic [7:0] WDATA;
  logic       FRAME_RDY;
  logic [4:0] FRAME_LEN;
  logic       FRAME_ACK;
  logic       ERR;
  logic [1:0] ERR_CODE;

  frame_capture_sequencer #(
    .SYNC1(8'hAA), .SYNC2(8'h55), .AW(4), .MAXLEN(16), .TIMEOUT(16)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .DBUS(DBUS), .DVALID(DVALID),
    .WREN(WREN), .WADDR(WADDR), .WDATA(WDATA),
    .FRAME_RDY(FRAME_RDY), .FRAME_LEN(FRAME_LEN), .FRAME_ACK(FRAME_ACK),
    .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       dvalid;
    logic [7:0] dbus;
    logic       ack;
    logic       wren;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       rdy;
    logic [4:0] len;
    logic       err;
    logic [1:0] code;
    logic       full;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  function automatic vec_t mk(string name, logic dv, logic [7:0] db, logic ack,
                              logic wren, logic [3:0] wa, logic [7:0] wd,
                              logic rdy, logic [4:0] len, logic err, logic [1:0] code);
    vec_t v;
    v.name = name; v.rst_n = 1'b1; v.dvalid = dv; v.dbus = db; v.ack = ack;
    v.wren = wren; v.waddr = wa; v.wdata = wd; v.rdy = rdy; v.len = len;
    v.err = err; v.code = code; v.full = 1'b0;
    return v;
  endfunction

  // No write, no error pulse.
  function automatic vec_t nop(string name, logic dv, logic [7:0] db, logic ack,
                               logic rdy, logic [4:0] len, logic [1:0] code);
    return mk(name, dv, db, ack, 1'b0, 4'h0, 8'h00, rdy, len, 1'b0, code);
  endfunction

  function automatic vec_t wr(string name, logic [7:0] db, logic [3:0] wa, logic [1:0] code);
    return mk(name, 1'b1, db, 1'b0, 1'b1, wa, db, 1'b0, 5'd0, 1'b0, code);
  endfunction

  function automatic vec_t er(string name, logic dv, logic [7:0] db, logic [1:0] code);
    return mk(name, dv, db, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 5'd0, 1'b1, code);
  endfunction

  // Reset cycle: every output must read back as zero.
  function automatic vec_t rst(string name);
    vec_t v;
    v = mk(name, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 5'd0, 1'b0, 2'b00);
    v.rst_n = 1'b0;
    v.full = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input vec_t v);
    logic ok;
    ok = (WREN === v.wren) && (FRAME_RDY === v.rdy) && (ERR === v.err) && (ERR_CODE === v.code);
    if (v.wren || v.full) ok = ok && (WADDR === v.waddr) && (WDATA === v.wdata);
    if (v.rdy || v.full)  ok = ok && (FRAME_LEN === v.len);
    applied++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL %s: got wren=%b waddr=%h wdata=%h rdy=%b len=%0d err=%b code=%b, want wren=%b waddr=%h wdata=%h rdy=%b len=%0d err=%b code=%b",
               v.name, WREN, WADDR, WDATA, FRAME_RDY, FRAME_LEN, ERR, ERR_CODE,
               v.wren, v.waddr, v.wdata, v.rdy, v.len, v.err, v.code);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    RST_N     = v.rst_n;
    DVALID    = v.dvalid;
    DBUS      = v.dbus;
    FRAME_ACK = v.ack;
    @(posedge CLK);
    #1;
    checkOutput(v);
  endtask

  initial begin
    RST_N = 1'b0; DVALID = 1'b0; DBUS = 8'h00; FRAME_ACK = 1'b0;

    applyStimulus(rst("reset0"));
    applyStimulus(rst("reset1"));

    // Good frame, then ack five cycles after FRAME_RDY rises.
    vecs.push_back(nop("gf_sync1", 1, 8'hAA, 0, 0, 0, 2'b00));
    vecs.push_back(nop("gf_sync2", 1, 8'h55, 0, 0, 0, 2'b00));
    vecs.push_back(nop("gf_len",   1, 8'h03, 0, 0, 0, 2'b00));
    vecs.push_back(wr("gf_p0", 8'h11, 4'd0, 2'b00));
    vecs.push_back(wr("gf_p1", 8'h22, 4'd1, 2'b00));
    vecs.push_back(wr("gf_p2", 8'h33, 4'd2, 2'b00));
    vecs.push_back(nop("gf_check", 1, 8'h66, 0, 1, 5'd3, 2'b00));
    for (int i = 0; i < 4; i++) vecs.push_back(nop("gf_hold", 0, 8'h00, 0, 1, 5'd3, 2'b00));
    vecs.push_back(nop("gf_ack",   0, 8'h00, 1, 0, 0, 2'b00));
    vecs.push_back(nop("gf_after", 0, 8'h00, 0, 0, 0, 2'b00));

    // Bad checksum; an ack outside HOLD must be ignored.
    vecs.push_back(nop("bc_sync1", 1, 8'hAA, 0, 0, 0, 2'b00));
    vecs.push_back(nop("bc_sync2_ack", 1, 8'h55, 1, 0, 0, 2'b00));
    vecs.push_back(nop("bc_len",   1, 8'h02, 0, 0, 0, 2'b00));
    vecs.push_back(wr("bc_p0", 8'h10, 4'd0, 2'b00));
    vecs.push_back(wr("bc_p1", 8'h20, 4'd1, 2'b00));
    vecs.push_back(er("bc_check", 1, 8'h31, 2'b11));
    vecs.push_back(nop("bc_after", 0, 8'h00, 0, 0, 0, 2'b11));

    // Bad lengths at both ends of the legal range.
    vecs.push_back(nop("bl_sync1a", 1, 8'hAA, 0, 0, 0, 2'b11));
    vecs.push_back(nop("bl_sync2a", 1, 8'h55, 0, 0, 0, 2'b11));
    vecs.push_back(er("bl_zero", 1, 8'h00, 2'b10));
    vecs.push_back(nop("bl_sync1b", 1, 8'hAA, 0, 0, 0, 2'b10));
    vecs.push_back(nop("bl_sync2b", 1, 8'h55, 0, 0, 0, 2'b10));
    vecs.push_back(er("bl_17", 1, 8'h11, 2'b10));
    vecs.push_back(nop("bl_after", 0, 8'h00, 0, 0, 0, 2'b10));

    // Resync on a doubled SYNC1 with 3-cycle gaps between bytes.
    vecs.push_back(nop("rs_aa0", 1, 8'hAA, 0, 0, 0, 2'b10));
    for (int i = 0; i < 3; i++) vecs.push_back(nop("rs_gap", 0, 8'h00, 0, 0, 0, 2'b10));
    vecs.push_back(nop("rs_aa1", 1, 8'hAA, 0, 0, 0, 2'b10));
    for (int i = 0; i < 3; i++) vecs.push_back(nop("rs_gap", 0, 8'h00, 0, 0, 0, 2'b10));
    vecs.push_back(nop("rs_55", 1, 8'h55, 0, 0, 0, 2'b10));
    for (int i = 0; i < 3; i++) vecs.push_back(nop("rs_gap", 0, 8'h00, 0, 0, 0, 2'b10));
    vecs.push_back(nop("rs_len", 1, 8'h01, 0, 0, 0, 2'b10));
    for (int i = 0; i < 3; i++) vecs.push_back(nop("rs_gap", 0, 8'h00, 0, 0, 0, 2'b10));
    vecs.push_back(wr("rs_p0", 8'h7F, 4'd0, 2'b10));
    for (int i = 0; i < 3; i++) vecs.push_back(nop("rs_gap", 0, 8'h00, 0, 0, 0, 2'b10));
    vecs.push_back(nop("rs_check", 1, 8'h7F, 0, 1, 5'd1, 2'b10));
    vecs.push_back(nop("rs_hold",  0, 8'h00, 0, 1, 5'd1, 2'b10));
    // SYNC1 in the ack cycle is dropped, so the bytes that follow start nothing.
    vecs.push_back(nop("ack_aa",   1, 8'hAA, 1, 0, 0, 2'b10));
    vecs.push_back(nop("ack_55",   1, 8'h55, 0, 0, 0, 2'b10));
    vecs.push_back(nop("ack_len",  1, 8'h01, 0, 0, 0, 2'b10));
    vecs.push_back(nop("ack_p0",   1, 8'h44, 0, 0, 0, 2'b10));
    vecs.push_back(nop("ack_chk",  1, 8'h44, 0, 0, 0, 2'b10));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Timeout: the 15th idle cycle is quiet, the 16th fires ERR.
    applyStimulus(nop("to_sync1", 1, 8'hAA, 0, 0, 0, 2'b10));
    applyStimulus(nop("to_sync2", 1, 8'h55, 0, 0, 0, 2'b10));
    applyStimulus(nop("to_len",   1, 8'h04, 0, 0, 0, 2'b10));
    applyStimulus(wr("to_p0", 8'h01, 4'd0, 2'b10));
    for (int i = 0; i < 15; i++) applyStimulus(nop("to_idle", 0, 8'h00, 0, 0, 0, 2'b10));
    applyStimulus(er("to_expire", 0, 8'h00, 2'b01));
    applyStimulus(nop("to_after", 0, 8'h00, 0, 0, 0, 2'b01));

    // A whole second frame arriving during HOLD is ignored.
    applyStimulus(nop("hd_sync1", 1, 8'hAA, 0, 0, 0, 2'b01));
    applyStimulus(nop("hd_sync2", 1, 8'h55, 0, 0, 0, 2'b01));
    applyStimulus(nop("hd_len",   1, 8'h01, 0, 0, 0, 2'b01));
    applyStimulus(wr("hd_p0", 8'h5A, 4'd0, 2'b01));
    applyStimulus(nop("hd_check", 1, 8'h5A, 0, 1, 5'd1, 2'b01));
    applyStimulus(nop("hd_ign_aa", 1, 8'hAA, 0, 1, 5'd1, 2'b01));
    applyStimulus(nop("hd_ign_55", 1, 8'h55, 0, 1, 5'd1, 2'b01));
    applyStimulus(nop("hd_ign_len", 1, 8'h02, 0, 1, 5'd1, 2'b01));
    applyStimulus(nop("hd_ign_p0", 1, 8'h01, 0, 1, 5'd1, 2'b01));
    applyStimulus(nop("hd_ign_p1", 1, 8'h02, 0, 1, 5'd1, 2'b01));
    applyStimulus(nop("hd_ign_chk", 1, 8'h03, 0, 1, 5'd1, 2'b01));
    applyStimulus(nop("hd_ack", 0, 8'h00, 1, 0, 0, 2'b01));

    // Reset mid-payload, then a clean frame lands at address 0.
    applyStimulus(nop("rm_sync1", 1, 8'hAA, 0, 0, 0, 2'b01));
    applyStimulus(nop("rm_sync2", 1, 8'h55, 0, 0, 0, 2'b01));
    applyStimulus(nop("rm_len",   1, 8'h03, 0, 0, 0, 2'b01));
    applyStimulus(wr("rm_p0", 8'hA1, 4'd0, 2'b01));
    applyStimulus(wr("rm_p1", 8'hA2, 4'd1, 2'b01));
    applyStimulus(rst("rm_reset"));
    applyStimulus(nop("rm2_sync1", 1, 8'hAA, 0, 0, 0, 2'b00));
    applyStimulus(nop("rm2_sync2", 1, 8'h55, 0, 0, 0, 2'b00));
    applyStimulus(nop("rm2_len",   1, 8'h02, 0, 0, 0, 2'b00));
    applyStimulus(wr("rm2_p0", 8'h0F, 4'd0, 2'b00));
    applyStimulus(wr("rm2_p1", 8'hF0, 4'd1, 2'b00));
    applyStimulus(nop("rm2_check", 1, 8'hFF, 0, 1, 5'd2, 2'b00));
    applyStimulus(nop("rm2_ack", 0, 8'h00, 1, 0, 0, 2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
